// File: rtl/pkt_rd_master.sv
// pkt_rd_master
//   Reads a byte region [pkt_begin, pkt_end) over an Avalon-MM host port in
//   bursts and pushes the returned words into a downstream FIFO.
//
//   Valid/ready semantics: a read command is offered by holding read high
//   with a stable address/burstcount; it is accepted on the rising edge where
//   read && !waitrequest. Only one burst is outstanding at a time. Each
//   readdatavalid beat seen in WAIT_DATA produces exactly one wr_to_fifo
//   cycle (registered, one clock later); the FIFO has no back-pressure on
//   that path, so almost_full only throttles the issue of new bursts.
//
//   Optional feature: define PKT_RD_4K_SPLIT_EN to stop bursts from crossing
//   a 4 KiB address boundary.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   rd_start                    start pulse, sampled only while idle
//   pkt_begin, pkt_end          byte region to read
//   almost_full                 downstream FIFO almost full
//   fifo_in, wr_to_fifo         FIFO data word and write strobe
//   fifo_last                   marks the final word of the region
//   rd_ctrl_rdy, err, busy      done pulse, bad-region pulse, not idle
//   address, read, burstcount   Avalon-MM command
//   readdata, readdatavalid     Avalon-MM read response
//   waitrequest                 Avalon-MM command stall
//   state_dbg                   current FSM state (IDLE=0 ISSUE=1 WAIT_DATA=2 DONE=3)

module pkt_rd_master #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] pkt_begin,
    input  logic [ADDR_W-1:0] pkt_end,
    input  logic              almost_full,
    output logic [DATA_W-1:0] fifo_in,
    output logic              wr_to_fifo,
    output logic              fifo_last,
    output logic              rd_ctrl_rdy,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic [15:0]       burstcount,
    input  logic [DATA_W-1:0] readdata,
    input  logic              readdatavalid,
    input  logic              waitrequest,
    output logic [1:0]        state_dbg
);

    localparam int                BYTES       = DATA_W / 8;
    localparam int                SHIFT       = $clog2(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   ROUND_UP    = (ADDR_W + 1)'(BYTES - 1);
    localparam logic [15:0]       MAX_BURST_W = 16'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       words_left;
    logic [15:0]       beat_cnt;

    logic [ADDR_W-1:0] aligned_begin;
    logic [ADDR_W:0]   span_bytes;
    logic [15:0]       total_words;
    logic              region_empty;
    logic              region_bad;
    logic              last_beat;
    logic [15:0]       burst_len;

    assign state_dbg = state;

    // Region decode from the live inputs; only consumed on the rd_start cycle.
    // The extra top bit keeps the round-up add from wrapping.
    always_comb begin
        aligned_begin = pkt_begin & ALIGN_MASK;
        span_bytes    = {1'b0, pkt_end - aligned_begin} + ROUND_UP;
        total_words   = 16'(span_bytes >> SHIFT);
        region_empty  = (pkt_end == pkt_begin);
        region_bad    = (pkt_end < pkt_begin);
    end

`ifdef PKT_RD_4K_SPLIT_EN
    logic [15:0] to_boundary;
`endif

    // Length of the next burst. cur_addr is always word aligned, so the
    // distance to the next 4 KiB boundary is an exact number of words.
    always_comb begin
        burst_len = (words_left > MAX_BURST_W) ? MAX_BURST_W : words_left;
`ifdef PKT_RD_4K_SPLIT_EN
        to_boundary = 16'((13'h1000 - {1'b0, cur_addr[11:0]}) >> SHIFT);
        if (to_boundary < burst_len) begin
            burst_len = to_boundary;
        end
`endif
    end

    assign last_beat = (state == WAIT_DATA) && readdatavalid &&
                       ((beat_cnt + 16'd1) == burstcount);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rd_start) begin
                    next_state = (region_empty || region_bad) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (read && !waitrequest) begin
                    next_state = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (last_beat) begin
                    next_state = (words_left == 16'd1) ? DONE : ISSUE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read        <= 1'b0;
            address     <= '0;
            burstcount  <= '0;
            fifo_in     <= '0;
            wr_to_fifo  <= 1'b0;
            fifo_last   <= 1'b0;
            rd_ctrl_rdy <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            cur_addr    <= '0;
            words_left  <= '0;
            beat_cnt    <= '0;
        end else begin
            wr_to_fifo  <= 1'b0;
            fifo_last   <= 1'b0;
            rd_ctrl_rdy <= (next_state == DONE);
            err         <= 1'b0;
            busy        <= (next_state != IDLE);

            case (state)
                IDLE: begin
                    if (rd_start) begin
                        cur_addr   <= aligned_begin;
                        words_left <= (region_empty || region_bad) ? 16'd0 : total_words;
                        beat_cnt   <= '0;
                        err        <= region_bad;
                    end
                end
                ISSUE: begin
                    // Command fields are loaded only when read rises, so they
                    // stay frozen for as long as waitrequest stalls us.
                    if (!read) begin
                        if (!almost_full) begin
                            read       <= 1'b1;
                            address    <= cur_addr;
                            burstcount <= burst_len;
                        end
                    end else if (!waitrequest) begin
                        read <= 1'b0;
                    end
                end
                WAIT_DATA: begin
                    if (readdatavalid) begin
                        fifo_in    <= readdata;
                        wr_to_fifo <= 1'b1;
                        fifo_last  <= (words_left == 16'd1);
                        words_left <= words_left - 16'd1;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            cur_addr <= cur_addr + (ADDR_W'(burstcount) << SHIFT);
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/pkt_rd_master.md
PKT_RD_MASTER -- requirements
Module: pkt_rd_master

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning Avalon readdata/FIFO width in bits (32, 64 or 128).
REQ-002 SHALL have parameter MAX_BURST, default 16, meaning maximum burst length in words (power of 2, 1..256).
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  in  1  clock; reset  in  1  async active-high reset.
REQ-005 SHALL have port rd_start  in  1  start pulse, sampled only in IDLE.
REQ-006 SHALL have ports pkt_begin, pkt_end  in  ADDR_W  byte region [pkt_begin, pkt_end).
REQ-007 SHALL have port almost_full  in  1  downstream FIFO almost full.
REQ-008 SHALL have ports fifo_in  out  DATA_W  data word; wr_to_fifo  out  1  write strobe; fifo_last  out  1  last word of packet, valid with wr_to_fifo.
REQ-009 SHALL have ports rd_ctrl_rdy  out  1  one-cycle done pulse; busy  out  1  not IDLE; err  out  1  one-cycle bad-region pulse.
REQ-010 SHALL have Avalon-MM host ports: address  out  ADDR_W; read  out  1; burstcount  out  16; readdata  in  DATA_W; readdatavalid  in  1; waitrequest  in  1.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT_DATA, DONE.
REQ-012 SHALL, on rd_start in IDLE, register pkt_begin/pkt_end and enter ISSUE next cycle; rd_start outside IDLE SHALL be ignored.
REQ-013 SHALL align start address down to DATA_W/8 bytes; total words = ceil((pkt_end - aligned_begin)/(DATA_W/8)).
REQ-014 SHALL, if pkt_end == pkt_begin, go IDLE->DONE with no read; if pkt_end < pkt_begin, additionally pulse err with rd_ctrl_rdy.
REQ-015 SHALL, in ISSUE with almost_full low, assert read with address and burstcount = min(remaining words, MAX_BURST); with almost_full high, read stays low.
REQ-016 SHALL hold read, address, burstcount stable while waitrequest is high; on read && !waitrequest, deassert read and enter WAIT_DATA.
REQ-017 SHALL keep at most one burst outstanding.
REQ-018 SHALL, in WAIT_DATA, count readdatavalid beats; after the burstcount-th beat, advance address by burstcount*(DATA_W/8) and go ISSUE if words remain, else DONE.
REQ-019 SHALL register readdata to fifo_in and assert wr_to_fifo exactly one cycle after each readdatavalid in WAIT_DATA; readdatavalid in other states SHALL be dropped.
REQ-020 SHALL assert fifo_last with the final word's wr_to_fifo only.
REQ-021 SHALL pulse rd_ctrl_rdy for one cycle in DONE, then return to IDLE.
REQ-022 SHALL use 16-bit remaining-word and beat counters; regions above 65535 words are out of scope.

Reset
REQ-023 SHALL asynchronously clear on reset: state=IDLE, read=0, wr_to_fifo=0, fifo_last=0, rd_ctrl_rdy=0, err=0, busy=0, address=0, burstcount=0, fifo_in=0, counters=0.
REQ-024 SHALL abandon any in-flight burst on reset mid-operation; late readdatavalid after reset SHALL not write the FIFO.

Configuration
REQ-025 SHALL support macro PKT_RD_4K_SPLIT_EN: when defined, burstcount is further limited so no burst crosses a 4 KiB address boundary; when undefined, bursts are limited only by REQ-015.

Verification
REQ-026 DATA_W=32, begin=0x1000, end=0x1040 -> one burst addr 0x1000 burstcount 16, 16 wr_to_fifo, fifo_last on 16th, one rd_ctrl_rdy pulse.
REQ-027 begin=0x2002, end=0x2049 -> 19 words: burst 16 @0x2000, then burst 3 @0x2040, fifo_last on 19th word.
REQ-028 waitrequest high 5 cycles during first read -> read/address/burstcount unchanged for all 5 cycles, single accepted command.
REQ-029 almost_full high at ISSUE for 10 cycles -> read low throughout; read asserts the cycle after almost_full drops.
REQ-030 begin=end=0x3000 -> rd_ctrl_rdy pulse, no read; begin=0x3010, end=0x3000 -> err and rd_ctrl_rdy same cycle, no read.
REQ-031 begin=0x0FF0, end=0x1030: with PKT_RD_4K_SPLIT_EN -> bursts 4 @0x0FF0 and 12 @0x1000; without -> one burst 16 @0x0FF0; reset mid-burst -> read=0 immediately, no further wr_to_fifo.
